// File: rtl/fp16_mul_round.sv
// fp16 multiplier normalize/round/pack: two-stage valid/ready pipeline
// producing a packed binary16 result and flags {invalid,overflow,underflow,inexact}.
// Ports: clk, rst_n (async low); in_valid/in_ready with in_sign, in_exp[6:0],
// in_prod[21:0], in_zero/in_inf/in_nan; out_valid/out_ready with
// out_result[15:0], out_flags[3:0].
// Build option: define FP16_MUL_RNE_EN for round-to-nearest-even
// (default build truncates; inexact is still reported).
module fp16_mul_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [21:0] in_prod,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags
);

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [9:0] man;
    logic       g;
    logic       st;
    logic       zero;
    logic       inf;
    logic       nan;
  } s1_t;

  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  s1_t  s1;
  s1_t  n_s1;

  logic [7:0]  r_exp;
  logic [9:0]  r_man;
  logic        inexact;
  logic [15:0] res;
  logic [3:0]  flg;

  assign s2_load   = !s2_valid | out_ready;
  assign s1_load   = !s1_valid | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    n_s1      = '0;
    n_s1.sign = in_sign;
    n_s1.zero = in_zero;
    n_s1.inf  = in_inf;
    n_s1.nan  = in_nan;
    n_s1.exp  = {in_exp[6], in_exp}
              + {7'b0, in_prod[21]};
    if (in_prod[21]) begin
      n_s1.man = in_prod[20:11];
      n_s1.g   = in_prod[10];
      n_s1.st  = |in_prod[9:0];
    end else begin
      n_s1.man = in_prod[19:10];
      n_s1.g   = in_prod[9];
      n_s1.st  = |in_prod[8:0];
    end
  end

`ifdef FP16_MUL_RNE_EN
  logic        inc;
  logic [10:0] sum;
  assign inc   = s1.g & (s1.st | s1.man[0]);
  assign sum   = {1'b0, s1.man} + {10'b0, inc};
  // carry-out leaves sum[9:0] at zero, so only the exponent moves
  assign r_man = sum[9:0];
  assign r_exp = s1.exp + {7'b0, sum[10]};
`else
  assign r_man = s1.man;
  assign r_exp = s1.exp;
`endif

  assign inexact = s1.g | s1.st;

  always_comb begin
    res = {s1.sign, r_exp[4:0], r_man};
    flg = {3'b000, inexact};
    if (s1.nan | (s1.inf & s1.zero)) begin
      res = 16'h7E00;
      flg = {s1.inf & s1.zero, 3'b000};
    end else if (s1.inf) begin
      res = {s1.sign, 15'h7C00};
      flg = 4'b0000;
    end else if (s1.zero) begin
      res = {s1.sign, 15'h0000};
      flg = 4'b0000;
    end else if ($signed(r_exp) >= 31) begin
      res = {s1.sign, 15'h7C00};
      flg = 4'b0101;
    end else if ($signed(r_exp) <= 0) begin
      res = {s1.sign, 15'h0000};
      flg = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1 <= n_s1;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res;
          out_flags  <= flg;
        end
      end
    end
  end

endmodule
